// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
// One request per 4'hF strobe, answered by a single-cycle resp pulse.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_addr,
    output imem_rmask,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_addr,
    input  imem_rmask,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, static not-taken
// prediction, stall buffering and flush/redirect with stale-response draining.

typedef struct packed {
  logic        monitor_valid;
  logic [63:0] monitor_order;
  logic [31:0] monitor_insn;
  logic        monitor_trap;
  logic        monitor_halt;
  logic        monitor_intr;
  logic [1:0]  monitor_mode;
  logic [1:0]  monitor_ixl;
  logic [4:0]  monitor_rs1_addr;
  logic [4:0]  monitor_rs2_addr;
  logic [31:0] monitor_rs1_rdata;
  logic [31:0] monitor_rs2_rdata;
  logic [4:0]  monitor_rd_addr;
  logic [31:0] monitor_rd_wdata;
  logic [31:0] monitor_pc_rdata;
  logic [31:0] monitor_pc_wdata;
  logic [31:0] monitor_mem_addr;
  logic [3:0]  monitor_mem_rmask;
  logic [3:0]  monitor_mem_wmask;
  logic [31:0] monitor_mem_rdata;
  logic [31:0] monitor_mem_wdata;
} rvfi_t;

typedef struct packed {
  logic [31:0] pc;
  logic        branch_pred;
  logic [31:0] predicted_pc;
  rvfi_t       rvfi;
} if_id_reg_t;

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       redirect_pc,
  if_stage_if.master        imem,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output if_id_reg_t        if_id_reg_next
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_plus4;
  logic [63:0] order, order_next;
  logic [31:0] buffer, buffer_next;
  logic [3:0]  rmask;

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      order  <= '0;
      buffer <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      order  <= order_next;
      buffer <= buffer_next;
    end
  end

  // Flush is tested first in every state so it always wins over stall and resp.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    order_next  = order;
    buffer_next = buffer;
    rmask       = 4'h0;
    inst        = NOP;
    inst_valid  = 1'b0;

    unique case (state)
      FETCH: begin
        if (flush) begin
          pc_next = redirect_pc;
        end else begin
          rmask      = rst ? 4'h0 : 4'hF;
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (flush) begin
          pc_next    = redirect_pc;
          state_next = imem.imem_resp ? FETCH : DRAIN;
        end else if (imem.imem_resp) begin
          inst       = imem.imem_rdata;
          inst_valid = 1'b1;
          if (stall) begin
            buffer_next = imem.imem_rdata;
            state_next  = HOLD;
          end else begin
            pc_next    = pc_plus4;
            order_next = order + 64'd1;
            state_next = FETCH;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          pc_next    = redirect_pc;
          state_next = FETCH;
        end else begin
          inst       = buffer;
          inst_valid = 1'b1;
          if (!stall) begin
            pc_next    = pc_plus4;
            order_next = order + 64'd1;
            state_next = FETCH;
          end
        end
      end

      DRAIN: begin
        // The abandoned request still owes us a response; swallow it first.
        if (flush) begin
          pc_next = redirect_pc;
        end
        if (imem.imem_resp) begin
          state_next = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign imem.imem_addr  = {pc[31:2], 2'b00};
  assign imem.imem_rmask = rmask;

  always_comb begin
    if_id_reg_next                       = '0;
    if_id_reg_next.pc                    = pc;
    if_id_reg_next.branch_pred           = 1'b0;
    if_id_reg_next.predicted_pc          = pc_plus4;
    if_id_reg_next.rvfi.monitor_valid    = inst_valid;
    if_id_reg_next.rvfi.monitor_order    = order;
    if_id_reg_next.rvfi.monitor_pc_rdata = pc;
    if_id_reg_next.rvfi.monitor_pc_wdata = pc_plus4;
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a latency-programmable memory model pushes the
// expected instruction on each response; transfers to decode pop and compare it.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic        inst_valid;
  if_id_reg_t  if_id_reg_next;

  if_stage_if mem_bus ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .imem           (mem_bus),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .if_id_reg_next (if_id_reg_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [63:0] order;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  logic        d_rst   = 1'b1;
  logic        d_stall = 1'b0;
  logic        d_flush = 1'b0;
  logic [31:0] d_rpc   = '0;

  int          latency    = 1;
  bit          pend       = 1'b0;
  bit          pend_stale = 1'b0;
  int          pend_cnt   = 0;
  logic [31:0] pend_addr  = '0;
  logic [63:0] model_order = '0;

  bit          obs_req;
  bit          obs_xfer;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // One clock: drive at negedge, let memory respond, sample 1ns later, score.
  task automatic tick();
    exp_t        e;
    rvfi_t       r;
    logic [31:0] exp_next;
    @(negedge clk);
    rst         = d_rst;
    stall       = d_stall;
    flush       = d_flush;
    redirect_pc = d_rpc;
    mem_bus.imem_resp  = 1'b0;
    mem_bus.imem_rdata = 32'hdeadbeef;
    if (d_rst) begin
      if (pend) pend_stale = 1'b1;
      sb_q.delete();
      model_order = '0;
    end
    if (d_flush) begin
      if (pend) pend_stale = 1'b1;
      sb_q.delete();
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        mem_bus.imem_resp  = 1'b1;
        mem_bus.imem_rdata = mem_word(pend_addr);
        pend = 1'b0;
        if (!pend_stale) sb_q.push_back('{pend_addr, mem_word(pend_addr), model_order});
      end else begin
        pend_cnt--;
      end
    end
    #1;
    obs_req  = (mem_bus.imem_rmask === 4'hF);
    obs_xfer = 1'b0;
    checks++;
    if (mem_bus.imem_rmask !== 4'h0 && mem_bus.imem_rmask !== 4'hF) begin
      errors++;
      $display("[TB] FAIL rmask_value: got %h required 0 or f", mem_bus.imem_rmask);
    end
    if (obs_req) begin
      checks++;
      if (pend) begin
        errors++;
        $display("[TB] FAIL one_outstanding: got new request at %h required none", mem_bus.imem_addr);
      end
      pend       = 1'b1;
      pend_stale = 1'b0;
      pend_cnt   = latency - 1;
      pend_addr  = mem_bus.imem_addr;
    end
    checks++;
    if (if_id_reg_next.rvfi.monitor_valid !== inst_valid || if_id_reg_next.branch_pred !== 1'b0) begin
      errors++;
      $display("[TB] FAIL monitor_valid: got %b/%b required %b/0", if_id_reg_next.rvfi.monitor_valid,
               if_id_reg_next.branch_pred, inst_valid);
    end
    if (inst_valid !== 1'b1) begin
      checks++;
      if (inst !== NOP) begin
        errors++;
        $display("[TB] FAIL nop_when_invalid: got %h required %h", inst, NOP);
      end
    end else if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL spurious_valid: got inst_valid=1 inst %h required 0", inst);
    end else begin
      e = sb_q[0];
      checks++;
      if (inst !== e.insn) begin
        errors++;
        $display("[TB] FAIL sb_inst: got %h required %h", inst, e.insn);
      end
      if (!d_stall) begin
        obs_xfer = 1'b1;
        exp_next = e.pc + 32'd4;
        checks++;
        if (if_id_reg_next.pc !== e.pc || if_id_reg_next.rvfi.monitor_pc_rdata !== e.pc) begin
          errors++;
          $display("[TB] FAIL sb_pc: got %h/%h required %h", if_id_reg_next.pc,
                   if_id_reg_next.rvfi.monitor_pc_rdata, e.pc);
        end
        checks++;
        if (if_id_reg_next.predicted_pc !== exp_next || if_id_reg_next.rvfi.monitor_pc_wdata !== exp_next) begin
          errors++;
          $display("[TB] FAIL sb_next_pc: got %h/%h required %h", if_id_reg_next.predicted_pc,
                   if_id_reg_next.rvfi.monitor_pc_wdata, exp_next);
        end
        checks++;
        if (if_id_reg_next.rvfi.monitor_order !== e.order) begin
          errors++;
          $display("[TB] FAIL sb_order: got %0d required %0d", if_id_reg_next.rvfi.monitor_order, e.order);
        end
        r = if_id_reg_next.rvfi;
        r.monitor_valid    = 1'b0;
        r.monitor_order    = '0;
        r.monitor_pc_rdata = '0;
        r.monitor_pc_wdata = '0;
        checks++;
        if (r !== '0) begin
          errors++;
          $display("[TB] FAIL rvfi_zero: got nonzero unused rvfi fields, insn %h required 0", r.monitor_insn);
        end
        void'(sb_q.pop_front());
        model_order++;
      end
    end
  endtask

  task automatic wait_req();
    d_stall = 1'b0;
    d_flush = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_req) break;
    end
    checks++;
    if (!obs_req) begin
      errors++;
      $display("[TB] FAIL wait_req_timeout: got no request in 12 cycles required one");
    end
  endtask

  task automatic test_reset();
    d_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_req || inst_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_quiet: got rmask %h valid %b required 0/0", mem_bus.imem_rmask, inst_valid);
      end
    end
    checks++;
    if (mem_bus.imem_addr !== RESET_PC || if_id_reg_next.rvfi.monitor_order !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got addr %h order %0d required %h 0", mem_bus.imem_addr,
               if_id_reg_next.rvfi.monitor_order, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    d_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs_req !== (c % 2 == 0) || (obs_req && mem_bus.imem_addr !== RESET_PC + 32'(4 * (c / 2)))) begin
        errors++;
        $display("[TB] FAIL seq_request_c%0d: got req %b addr %h required req %b addr %h", c, obs_req,
                 mem_bus.imem_addr, (c % 2 == 0), RESET_PC + 32'(4 * (c / 2)));
      end
      if (c % 2 == 1) begin
        checks++;
        if (inst_valid !== 1'b1 || if_id_reg_next.rvfi.monitor_order !== 64'(c / 2)) begin
          errors++;
          $display("[TB] FAIL seq_order_c%0d: got valid %b order %0d required 1 %0d", c, inst_valid,
                   if_id_reg_next.rvfi.monitor_order, c / 2);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    wait_req();
    a = mem_bus.imem_addr;
    d_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) d_stall = 1'b0;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== mem_word(a) || obs_req || if_id_reg_next.pc !== a) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: got valid %b inst %h req %b pc %h required 1 %h 0 %h", i,
                 inst_valid, inst, obs_req, if_id_reg_next.pc, mem_word(a), a);
      end
    end
    tick();
    checks++;
    if (!obs_req || mem_bus.imem_addr !== a + 32'd4) begin
      errors++;
      $display("[TB] FAIL stall_advance: got req %b addr %h required 1 %h", obs_req, mem_bus.imem_addr, a + 32'd4);
    end
  endtask

  task automatic test_flush_wait();
    latency = 3;
    wait_req();
    d_flush = 1'b1;
    d_rpc   = 32'h1eceb0c0;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || obs_req) begin
      errors++;
      $display("[TB] FAIL flush_wait: got valid %b req %b required 0 0", inst_valid, obs_req);
    end
    d_rpc = 32'h1eceb100;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) d_flush = 1'b0;
      tick();
      checks++;
      if (inst_valid !== 1'b0 || obs_req) begin
        errors++;
        $display("[TB] FAIL drain_%0d: got valid %b req %b required 0 0", i, inst_valid, obs_req);
      end
    end
    tick();
    checks++;
    if (!obs_req || mem_bus.imem_addr !== 32'h1eceb100) begin
      errors++;
      $display("[TB] FAIL drain_redirect: got req %b addr %h required 1 1eceb100", obs_req, mem_bus.imem_addr);
    end
    latency = 1;
  endtask

  task automatic test_flush_resp();
    logic [63:0] saved;
    wait_req();
    saved   = model_order;
    d_flush = 1'b1;
    d_rpc   = 32'h1eceb240;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || inst !== NOP) begin
      errors++;
      $display("[TB] FAIL flush_resp: got valid %b inst %h required 0 %h", inst_valid, inst, NOP);
    end
    d_flush = 1'b0;
    tick();
    checks++;
    if (!obs_req || mem_bus.imem_addr !== 32'h1eceb240 || if_id_reg_next.rvfi.monitor_order !== saved) begin
      errors++;
      $display("[TB] FAIL flush_resp_next: got req %b addr %h order %0d required 1 1eceb240 %0d", obs_req,
               mem_bus.imem_addr, if_id_reg_next.rvfi.monitor_order, saved);
    end
  endtask

  task automatic test_wrap();
    tick();
    d_flush = 1'b1;
    d_rpc   = 32'hfffffffc;
    tick();
    checks++;
    if (obs_req) begin
      errors++;
      $display("[TB] FAIL fetch_flush: got request at %h required none", mem_bus.imem_addr);
    end
    d_flush = 1'b0;
    tick();
    checks++;
    if (!obs_req || mem_bus.imem_addr !== 32'hfffffffc) begin
      errors++;
      $display("[TB] FAIL wrap_req: got req %b addr %h required 1 fffffffc", obs_req, mem_bus.imem_addr);
    end
    tick();
    checks++;
    if (!obs_xfer || if_id_reg_next.predicted_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_pred: got xfer %b predicted %h required 1 00000000", obs_xfer,
               if_id_reg_next.predicted_pc);
    end
    tick();
    checks++;
    if (!obs_req || mem_bus.imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_next: got req %b addr %h required 1 00000000", obs_req, mem_bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    latency = 3;
    wait_req();
    tick();
    d_rst = 1'b1;
    tick();
    checks++;
    if (obs_req || inst_valid !== 1'b0 || mem_bus.imem_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL mid_reset: got req %b valid %b addr %h required 0 0 %h", obs_req, inst_valid,
               mem_bus.imem_addr, RESET_PC);
    end
    d_rst = 1'b0;
    tick();
    checks++;
    if (!obs_req || mem_bus.imem_addr !== RESET_PC || if_id_reg_next.rvfi.monitor_order !== 64'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_req: got req %b addr %h order %0d required 1 %h 0", obs_req,
               mem_bus.imem_addr, if_id_reg_next.rvfi.monitor_order, RESET_PC);
    end
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = obs_xfer;
    end
    checks++;
    if (!seen || if_id_reg_next.pc !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL mid_reset_first: got xfer %b pc %h required 1 %h", seen, if_id_reg_next.pc, RESET_PC);
    end
    latency = 1;
  endtask

  task automatic test_back_to_back();
    int xfers;
    wait_req();
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_xfer) xfers++;
    end
    checks++;
    if (xfers != 5) begin
      errors++;
      $display("[TB] FAIL throughput: got %0d transfers in 10 cycles required 5", xfers);
    end
    xfers = 0;
    for (int i = 0; i < 60; i++) begin
      d_stall = ($urandom_range(0, 3) == 0);
      tick();
      if (obs_xfer) xfers++;
    end
    d_stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (xfers < 10) begin
      errors++;
      $display("[TB] FAIL random_stall_progress: got %0d transfers required at least 10", xfers);
    end
  endtask

  initial begin
    $display("[TB] if_stage bench starting");
    test_reset();
    test_sequential();
    test_stall();
    test_flush_wait();
    test_flush_resp();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000 required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL be parameterised by RESET_PC, default 32'h1eceb000, the fetch address loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 stall  input  1  decode/hazard stage not accepting; holds the current instruction.
REQ-005 flush  input  1  redirect request from execute (mispredict, jal, or jalr).
REQ-006 redirect_pc  input  32  new fetch PC; sampled only when flush=1.
REQ-007 imem_addr  output  32  instruction memory address, equal to {pc[31:2],2'b00}.
REQ-008 imem_rmask  output  4  read strobe; 4'hF for one cycle per request, else 4'h0.
REQ-009 imem_rdata  input  32  instruction word; valid only when imem_resp=1.
REQ-010 imem_resp  input  1  single-cycle response pulse, at least one cycle after the request.
REQ-011 inst  output  32  instruction presented to decode.
REQ-012 inst_valid  output  1  inst and if_id_reg_next are meaningful this cycle.
REQ-013 if_id_reg_next  output  if_id_reg_t  pc, branch_pred, predicted_pc, and rvfi monitor fields for the IF/ID register.

Function
REQ-014 The block SHALL hold a 32-bit pc register, a 64-bit order counter, a 32-bit instruction buffer, and a 4-state FSM {FETCH, WAIT, HOLD, DRAIN}.
REQ-015 In FETCH with flush=0, the block SHALL drive imem_rmask=4'hF and go to WAIT. In FETCH with flush=1, it SHALL drive imem_rmask=0, load pc<=redirect_pc, and stay in FETCH.
REQ-016 In WAIT with imem_resp=1 and flush=0, the block SHALL drive inst=imem_rdata and inst_valid=1 in the same cycle.
REQ-017 In WAIT with imem_resp=1, flush=0, and stall=0, the instruction transfers: pc<=pc+4, order<=order+1, state->FETCH.
REQ-018 In WAIT with imem_resp=1, flush=0, and stall=1, the block SHALL load imem_rdata into the buffer and go to HOLD; pc and order are unchanged.
REQ-019 In WAIT with imem_resp=1 and flush=1, the block SHALL discard the response, drive inst_valid=0, load pc<=redirect_pc, and go to FETCH.
REQ-020 In WAIT with imem_resp=0 and flush=1, the block SHALL load pc<=redirect_pc and go to DRAIN.
REQ-021 In HOLD, the block SHALL drive inst=buffer and inst_valid=1.
REQ-022 In HOLD with flush=1, it SHALL drive inst_valid=0, load pc<=redirect_pc, and go to FETCH. In HOLD with flush=0 and stall=0, it SHALL transfer as in REQ-017.
REQ-023 In DRAIN, the block SHALL drive inst_valid=0 and go to FETCH on imem_resp, discarding the data. A further flush in DRAIN SHALL only update pc.
REQ-024 flush SHALL take priority over stall and over imem_resp in every state.
REQ-025 imem_resp arriving in FETCH or HOLD SHALL be ignored.
REQ-026 imem_rmask SHALL be 0 in WAIT, HOLD, and DRAIN, so at most one request is outstanding.
REQ-027 pc+4 SHALL wrap modulo 2^32. order SHALL wrap modulo 2^64.
REQ-028 if_id_reg_next SHALL carry: pc=pc; branch_pred=0 (static not-taken); predicted_pc=pc+4; rvfi.monitor_valid=inst_valid; rvfi.monitor_order=order; rvfi.monitor_pc_rdata=pc; rvfi.monitor_pc_wdata=pc+4. All other rvfi fields SHALL be 0.
REQ-029 When inst_valid=0, inst SHALL be 32'h00000013 (nop).
REQ-030 Maximum throughput SHALL be one instruction per two cycles when memory responds in one cycle.

Reset
REQ-031 While rst=1, the block SHALL hold: pc=RESET_PC, order=0, buffer=0, state=FETCH, imem_rmask=0, inst_valid=0.
REQ-032 The first request SHALL be issued in the first clock edge cycle after rst deasserts, with imem_addr=RESET_PC.
REQ-033 Reset asserted with a request outstanding SHALL abandon it; a late imem_resp after reset SHALL be ignored per REQ-025.

Verification
REQ-034 Reset release, 1-cycle memory, stall=0 -> addresses 1eceb000, 1eceb004, 1eceb008 issued in cycles 0, 2, 4; monitor_order 0, 1, 2.
REQ-035 Response with stall=1 for 3 cycles -> inst_valid stays 1 with an unchanged inst for 4 cycles; pc advances only after stall drops; no new request issued meanwhile.
REQ-036 flush with redirect_pc=32'h1eceb100 in WAIT before the response -> DRAIN; stale data never marked valid; next imem_addr=1eceb100.
REQ-037 flush coincident with imem_resp -> inst_valid=0 that cycle; order unchanged; next request to redirect_pc.
REQ-038 pc=32'hfffffffc transfer -> next imem_addr=32'h00000000; rst pulsed mid-WAIT -> next request at RESET_PC with order=0.
